// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: streams ifmap/weight/bias operands into one PE and
// returns the finished opsum over valid/ready. Option: PE_FEED_ZERO_SKIP_EN.
module pe_operand_feeder #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [LEN_W-1:0]  cfg_num_out,
    input  logic [ADDR_W-1:0] cfg_if_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] if_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              if_rd,
    output logic              w_rd,
    input  logic [DATA_W-1:0] if_data,
    input  logic [DATA_W-1:0] w_data,
    output logic [LEN_W-1:0]  b_addr,
    input  logic [ACC_W-1:0]  b_data,
    output logic [DATA_W-1:0] pe_ifmap,
    output logic [DATA_W-1:0] pe_weight,
    output logic [ACC_W-1:0]  pe_bias,
    output logic              pe_en,
    output logic              pe_first,
    input  logic [ACC_W-1:0]  pe_opsum,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LAST,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [LEN_W-1:0]  L_ONE = LEN_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    state_t r_state;
    state_t w_next;

    logic [LEN_W-1:0]  r_k;
    logic [LEN_W-1:0]  r_n;
    logic [LEN_W-1:0]  r_beat;
    logic [LEN_W-1:0]  r_oidx;
    logic [ADDR_W-1:0] r_if_ptr;
    logic [ADDR_W-1:0] r_w_ptr;
    logic              r_v;
    logic              r_first;
    logic              r_done;
    logic [ACC_W-1:0]  r_out_data;

    logic w_issue;
    logic w_last_beat;
    logic w_last_out;

    assign w_issue     = (r_state == S_ISSUE);
    assign w_last_beat = (r_beat == r_k - L_ONE);
    assign w_last_out  = (r_oidx == r_n - L_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start && cfg_num_out != '0) w_next = S_ISSUE;
            S_ISSUE: if (w_last_beat) w_next = S_LAST;
            S_LAST:  w_next = S_WAIT;
            S_WAIT:  w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = w_last_out ? S_IDLE : S_ISSUE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job config, pointers, counters, opsum capture and PE-side pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_n        <= '0;
            r_beat     <= '0;
            r_oidx     <= '0;
            r_if_ptr   <= '0;
            r_w_ptr    <= '0;
            r_v        <= 1'b0;
            r_first    <= 1'b0;
            r_done     <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_v     <= w_issue;
            r_first <= w_issue && (r_beat == '0);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k      <= (cfg_len == '0) ? L_ONE : cfg_len;
                        r_n      <= cfg_num_out;
                        r_if_ptr <= cfg_if_base;
                        r_w_ptr  <= cfg_w_base;
                        r_oidx   <= '0;
                        r_beat   <= '0;
                        r_done   <= (cfg_num_out == '0);
                    end
                end
                S_ISSUE: begin
                    r_if_ptr <= r_if_ptr + A_ONE;
                    r_w_ptr  <= r_w_ptr + A_ONE;
                    r_beat   <= r_beat + L_ONE;
                end
                S_WAIT: r_out_data <= pe_opsum;
                S_OUT: begin
                    if (out_ready) begin
                        r_beat <= '0;
                        r_oidx <= r_oidx + L_ONE;
                        r_done <= w_last_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign if_rd   = w_issue;
    assign w_rd    = w_issue;
    assign if_addr = w_issue ? r_if_ptr : '0;
    assign w_addr  = w_issue ? r_w_ptr : '0;
    assign b_addr  = w_issue ? r_oidx : '0;

    assign pe_ifmap  = r_v ? if_data : '0;
    assign pe_weight = r_v ? w_data : '0;
    assign pe_bias   = r_first ? b_data : '0;
    assign pe_first  = r_first;

`ifdef PE_FEED_ZERO_SKIP_EN
    // A zero ifmap adds nothing; beat 0 always fires to load the bias.
    assign pe_en = r_v && (r_first || if_data != '0);
`else
    assign pe_en = r_v;
`endif

    assign out_data  = r_out_data;
    assign out_valid = (r_state == S_OUT);

endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb_pe_operand_feeder: buffers and PE modelled around the feeder;
// expected opsums computed directly from buffer contents.
module tb_pe_operand_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [7:0]  cfg_num_out = '0;
    logic [9:0]  cfg_if_base = '0;
    logic [9:0]  cfg_w_base = '0;
    logic        busy, done;
    logic [9:0]  if_addr, w_addr;
    logic        if_rd, w_rd;
    logic [7:0]  if_data = '0;
    logic [7:0]  w_data = '0;
    logic [7:0]  b_addr;
    logic [31:0] b_data = '0;
    logic [7:0]  pe_ifmap, pe_weight;
    logic [31:0] pe_bias;
    logic        pe_en, pe_first;
    logic [31:0] pe_opsum;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ifm [1024];
    logic [7:0]  wm  [1024];
    logic [31:0] bm  [256];
    logic [31:0] acc = '0;

    pe_operand_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_num_out(cfg_num_out),
        .cfg_if_base(cfg_if_base), .cfg_w_base(cfg_w_base),
        .busy(busy), .done(done),
        .if_addr(if_addr), .w_addr(w_addr),
        .if_rd(if_rd), .w_rd(w_rd),
        .if_data(if_data), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .pe_ifmap(pe_ifmap), .pe_weight(pe_weight),
        .pe_bias(pe_bias), .pe_en(pe_en), .pe_first(pe_first),
        .pe_opsum(pe_opsum),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Single-port buffers with one-cycle read latency
    always @(posedge clk) begin
        if (if_rd) if_data <= ifm[if_addr];
        if (w_rd)  w_data  <= wm[w_addr];
        if (if_rd) b_data  <= bm[b_addr];
    end

    // PE: registered multiply-accumulate
    always @(posedge clk) begin
        if (pe_en)
            acc <= (pe_first ? pe_bias : acc)
                 + 32'(pe_ifmap) * 32'(pe_weight);
    end
    assign pe_opsum = acc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        logic [63:0] v;
        v = {busy, done, if_rd, w_rd, pe_en, pe_first, out_valid};
        chk({tag, "_ctl"}, v, 0);
        chk({tag, "_addr"}, {if_addr, w_addr, b_addr}, 0);
        chk({tag, "_pe"}, {pe_ifmap, pe_weight, pe_bias}, 0);
        chk({tag, "_out"}, out_data, 0);
    endtask

    task automatic run_job(input int k, input int n, input int ifb,
                           input int wb, input int hold, input bit stray,
                           output logic [7:0] pat);
        int ke, issued, pecnt, pexp, outs, dones, c;
        int last_hs, wait_c, first_iss, done_c, a, b;
        logic [31:0] expv [$];
        logic [31:0] held, s;
        bit vprev, fin;
        ke = (k == 0) ? 1 : k;
        pexp = 0;
        for (int o = 0; o < n; o++) begin
            s = bm[o];
            for (int j = 0; j < ke; j++) begin
                a = (ifb + o * ke + j) % 1024;
                b = (wb + o * ke + j) % 1024;
                s = s + 32'(ifm[a]) * 32'(wm[b]);
`ifdef PE_FEED_ZERO_SKIP_EN
                if (j == 0 || ifm[a] != 0) pexp++;
`else
                pexp++;
`endif
            end
            expv.push_back(s);
        end
        issued = 0; pecnt = 0; outs = 0; dones = 0; c = 0;
        last_hs = -100; wait_c = 0; first_iss = 0; done_c = -1;
        held = '0; vprev = 0; fin = 0; pat = '0;
        @(negedge clk);
        start = 1'b1;
        cfg_len = 8'(k);
        cfg_num_out = 8'(n);
        cfg_if_base = 10'(ifb);
        cfg_w_base = 10'(wb);
        out_ready = (hold == 0);
        while (!fin && c < 400) begin
            @(negedge clk);
            c++;
            start = stray && (c == 3);
            if (if_rd) begin
                chk("if_addr", if_addr, (ifb + issued) % 1024);
                chk("w_addr", w_addr, (wb + issued) % 1024);
                chk("b_addr", b_addr, issued / ke);
                if (issued % ke == 0) first_iss = c;
                issued++;
            end
            if (c >= 2 && c < 10) pat[c-2] = pe_en;
            if (pe_en) begin
                if (pecnt == 0) chk("first_en_lat", c, 2);
                pecnt++;
            end
            if (out_valid) begin
                if (!vprev) begin
                    chk("out_data", out_data, (outs < n) ? expv[outs] : 0);
                    chk("valid_lat", c - first_iss, ke + 2);
                    held = out_data;
                    wait_c = 0;
                end else begin
                    chk("out_stable", out_data, held);
                end
                out_ready = (wait_c >= hold);
                wait_c++;
                if (out_ready) begin
                    outs++;
                    last_hs = c;
                end
                vprev = !out_ready;
            end else begin
                out_ready = (hold == 0);
                vprev = 0;
            end
            if (done) begin
                dones++;
                chk("done_time", c, (n == 0) ? 1 : last_hs + 1);
                chk("busy_at_done", busy, 0);
                done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) fin = 1;
        end
        chk("timeout", fin, 1);
        chk("num_outputs", outs, n);
        chk("num_done", dones, 1);
        chk("pe_en_count", pecnt, pexp);
        chk("issue_count", issued, n * ke);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int dn;
        for (int i = 0; i < 1024; i++) begin
            ifm[i] = 8'($urandom);
            wm[i]  = 8'($urandom);
        end
        for (int i = 0; i < 256; i++) bm[i] = $urandom;

        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // K=4 N=1 basic dot product
        for (int i = 0; i < 4; i++) begin
            ifm[10+i] = 8'(i + 1);
            wm[20+i] = 8'd1;
        end
        bm[0] = 32'h10;
        run_job(4, 1, 10, 20, 0, 0, pat);
        chk("t1_pat", pat[3:0], 4'b1111);
        chk("t1_value", out_data, 32'h1A);

        // K=3 N=2 with bias wrap
        for (int i = 0; i < 6; i++) begin
            ifm[100+i] = 8'd2;
            wm[200+i] = 8'd2;
        end
        bm[0] = 32'd5;
        bm[1] = 32'hFFFF_FFFF;
        run_job(3, 2, 100, 200, 0, 1, pat);
        chk("t2_value", out_data, 32'h0000_000B);

        // Backpressure held five cycles
        run_job(2, 1, 300, 400, 5, 0, pat);

        // Empty job
        run_job(1, 0, 0, 0, 0, 0, pat);
        chk("t4_pat", pat, 0);
        chk("t4_busy", busy, 0);

        // Reset in the middle of an issue stream
        @(negedge clk);
        start = 1'b1;
        cfg_len = 8'd8;
        cfg_num_out = 8'd1;
        cfg_if_base = 10'd50;
        cfg_w_base = 10'd60;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_in_issue", if_rd, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("t5_rst");
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("t5_no_done", dn, 0);
        run_job(3, 1, 70, 80, 1, 0, pat);

        // Zero ifmap beats
        ifm[500] = 8'd3; ifm[501] = 8'd0; ifm[502] = 8'd0; ifm[503] = 8'd2;
        for (int i = 0; i < 4; i++) wm[600+i] = 8'd1;
        bm[0] = 32'd0;
        run_job(4, 1, 500, 600, 0, 0, pat);
`ifdef PE_FEED_ZERO_SKIP_EN
        chk("t6_pat", pat[3:0], 4'b1001);
`else
        chk("t6_pat", pat[3:0], 4'b1111);
`endif
        chk("t6_value", out_data, 32'd5);

        // Randomised jobs, including zero K and address wrap
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 1024; i++)
                ifm[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            run_job($urandom_range(0, 6), $urandom_range(1, 3),
                    (t % 3 == 0) ? $urandom_range(1015, 1023)
                                 : $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), pat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Producer side of the PE operand interface. Reads ifmap and weight bytes from two single-port buffers with 1-cycle read latency, and bias words from a bias buffer.
- Streams the operands into one PE at one MAC per cycle, then captures the finished opsum and hands it downstream over a valid/ready port.
- Sits between the on-chip buffers and the PE. The controller kicks one job via start/done.

Parameters:
- DATA_W, 8, ifmap/weight element width
- ACC_W, 32, bias/opsum width (4*DATA_W)
- ADDR_W, 10, buffer address width
- LEN_W, 8, width of MAC-count and output-count config fields

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle job kick; ignored unless idle
- cfg_len  in  LEN_W  MACs per output (K); 0 treated as 1
- cfg_num_out  in  LEN_W  outputs in job (N); 0 means job completes immediately
- cfg_if_base / cfg_w_base  in  ADDR_W  start addresses
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- if_addr / w_addr  out  ADDR_W  buffer read addresses
- if_rd / w_rd  out  1  read enables
- if_data / w_data  in  DATA_W  read data, valid the cycle after rd
- b_addr  out  LEN_W  bias index (= output index)
- b_data  in  ACC_W  bias word, valid the cycle after if_rd of beat 0
- pe_ifmap / pe_weight  out  DATA_W  PE operands
- pe_bias  out  ACC_W  PE bias
- pe_en  out  1  PE MAC enable
- pe_first  out  1  high on beat 0; PE loads bias + ifmap*weight instead of accumulating
- pe_opsum  in  ACC_W  PE result, registered, valid 1 cycle after the last pe_en
- out_data  out  ACC_W  captured opsum
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept

Behaviour:
- Reset (clk-synchronous, rst active-high; clock clk): all outputs 0, FSM=IDLE, counters 0. Any in-flight job is abandoned with no done pulse.
- FSM states: IDLE, ISSUE, LAST, WAIT, OUT.
- IDLE: on start, latch config and set if_ptr/w_ptr to the bases, oidx=0, beat=0, busy=1.
  - If N==0: pulse done next cycle, stay IDLE.
  - Else go to ISSUE.
- ISSUE: each cycle assert if_rd/w_rd with if_ptr/w_ptr; b_addr=oidx; increment pointers and beat.
  - When beat==K-1, go to LAST.
- Data path: one cycle after each issue, pe_en=1 and pe_ifmap/pe_weight = if_data/w_data. pe_first=1 and pe_bias=b_data only for beat 0; otherwise pe_bias=0.
- LAST: the final beat's data reaches the PE this cycle; go to WAIT.
- WAIT: pe_opsum is valid. Capture it into out_data, set out_valid=1, go to OUT.
- OUT: hold out_data/out_valid stable until out_ready. The handshake completes on the cycle valid&&ready.
  - Then oidx++, beat=0. If oidx==N-1, pulse done, busy=0, go to IDLE. Else go to ISSUE.
  - Addresses continue linearly across outputs; no rewind.
- Latency: first PE enable = start+2 cycles. out_valid rises K+2 cycles after entering ISSUE.
- No stall inside a beat stream; backpressure acts only in OUT.
- Addresses wrap modulo 2^ADDR_W silently.
- start while busy: ignored.
- out_ready high before out_valid: no effect.

Optional Feature:
- PE_FEED_ZERO_SKIP_EN. When defined, pe_en is forced 0 on any non-first beat whose if_data==0. PE operands are still driven; results are identical and switching activity drops.
- Without the macro, pe_en is high on every beat.
- Beat 0 is never skipped, because it loads the bias.

Test Plan:
- K=4, N=1, if={1,2,3,4}, w={1,1,1,1}, bias=0x10, out_ready=1 -> pe_en high 4 cycles; out_data=0x1A; done 1 cycle after the handshake.
- K=3, N=2, bias={5, 0xFFFFFFFF}, all if/w=2 -> outputs 0x11 then 0x0000000B (wrap mod 2^32); if_addr runs base..base+5.
- K=2, N=1, out_ready held 0 for 5 cycles -> out_valid/out_data stable for all 5 cycles; accepted on cycle 6; exactly one done.
- N=0 with start -> done pulse, no if_rd, no pe_en, busy returns 0.
- rst asserted mid-ISSUE of a K=8 job -> next cycle all outputs 0, FSM idle, no done; a new start then runs cleanly.
- PE_FEED_ZERO_SKIP_EN defined, if={3,0,0,2}, w={1,1,1,1}, bias=0 -> pe_en pattern 1,0,0,1; out_data=5. Undefined -> pattern 1,1,1,1; out_data=5.
